// File: rtl/pipelined_control_unit.sv
// RV32IM decode stage: decodes INSTRUCTION into the ID/EX control register and
// stalls the front end while a multi-cycle MUL/DIV occupies EX.
module pipelined_control_unit #(
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IN_VALID,
  input  logic        STALL,
  input  logic        FLUSH,
  output logic        READY,
  output logic        OUT_VALID,
  output logic        ILLEGAL,
  output logic        MULDIV_START,
  output logic [4:0]  alu_signal,
  output logic        reg_file_write,
  output logic [2:0]  main_mem_write,
  output logic [3:0]  main_mem_read,
  output logic [3:0]  branch_control,
  output logic [3:0]  immediate_select,
  output logic        oparand_1_select,
  output logic        oparand_2_select,
  output logic [1:0]  reg_write_select
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  typedef struct packed {
    logic [4:0] alu;
    logic       rfw;
    logic [2:0] mw;
    logic [3:0] mr;
    logic [3:0] bc;
    logic [3:0] imm;
    logic       op1;
    logic       op2;
    logic [1:0] rws;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '{alu: '0, rfw: 1'b0, mw: '0, mr: '0, bc: '0,
                                 imm: '0, op1: 1'b0, op2: 1'b0, rws: 2'b01};

  opcode_e     opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  ctrl_t       dec_ctrl;
  logic        dec_illegal;
  logic        dec_mop;
  int unsigned mop_lat;
  logic        unused_instr_bits;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic             start_q, start_d;

  assign opc = opcode_e'(INSTRUCTION[6:0]);
  assign f3  = INSTRUCTION[14:12];
  assign f7  = INSTRUCTION[31:25];
  assign unused_instr_bits = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

  always_comb begin
    dec_ctrl    = NOP_CTRL;
    dec_illegal = 1'b0;
    dec_mop     = 1'b0;
    mop_lat     = f3[2] ? DIV_LATENCY : MUL_LATENCY;
    case (opc)
      OPC_LUI: begin
        dec_ctrl.alu = 5'b11000;
        dec_ctrl.rfw = 1'b1;
        dec_ctrl.op2 = 1'b1;
      end
      OPC_AUIPC: begin
        dec_ctrl.rfw = 1'b1;
        dec_ctrl.op1 = 1'b1;
        dec_ctrl.op2 = 1'b1;
        dec_ctrl.rws = 2'b11;
      end
      OPC_JAL, OPC_JALR: begin
        dec_ctrl.rfw = 1'b1;
        dec_ctrl.bc  = 4'b1010;
        dec_ctrl.imm = (opc == OPC_JAL) ? 4'b0001 : 4'b0010;
        dec_ctrl.op1 = 1'b1;
        dec_ctrl.op2 = 1'b1;
        dec_ctrl.rws = 2'b11;
      end
      OPC_BRANCH: begin
        dec_ctrl.bc  = {1'b1, f3};
        dec_ctrl.imm = 4'b0011;
        dec_ctrl.op1 = 1'b1;
        dec_ctrl.op2 = 1'b1;
      end
      OPC_LOAD: begin
        dec_ctrl.rfw = 1'b1;
        dec_ctrl.mr  = {1'b1, f3};
        dec_ctrl.imm = {(f3 == 3'b100) || (f3 == 3'b101), 3'b010};
        dec_ctrl.op2 = 1'b1;
        dec_ctrl.rws = 2'b00;
      end
      OPC_STORE: begin
        dec_ctrl.mw  = {1'b1, f3[1:0]};
        dec_ctrl.imm = 4'b0100;
        dec_ctrl.op2 = 1'b1;
      end
      OPC_OPIMM: begin
        dec_ctrl.alu = {(f3 == 3'b101) && INSTRUCTION[30], 1'b0, f3};
        dec_ctrl.rfw = 1'b1;
        dec_ctrl.imm = {f3 == 3'b011,
                        ((f3 == 3'b001) || (f3 == 3'b101)) ? 3'b101 : 3'b010};
        dec_ctrl.op2 = 1'b1;
      end
      OPC_OP: begin
        dec_mop      = (f7 == 7'b0000001);
        dec_ctrl.alu = {(f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)),
                        dec_mop, f3};
        dec_ctrl.rfw = 1'b1;
        dec_ctrl.imm = {((f7 == 7'b0000000) && (f3 == 3'b011)) ||
                        (dec_mop && ((f3 == 3'b010) || (f3 == 3'b011) || (f3 == 3'b111))),
                        3'b000};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ctrl_q    <= NOP_CTRL;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      start_q   <= start_d;
    end
  end

  // MULDIV_START is a strict one-cycle pulse, so it is not held across a STALL.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    start_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (FLUSH || !STALL) begin
          ctrl_d    = NOP_CTRL;
          valid_d   = 1'b0;
          illegal_d = 1'b0;
          if (!FLUSH && IN_VALID) begin
            valid_d = 1'b1;
            if (dec_illegal) begin
              illegal_d = 1'b1;
            end else begin
              ctrl_d  = dec_ctrl;
              start_d = dec_mop;
              if (dec_mop && (mop_lat > 1)) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(mop_lat - 1);
              end
            end
          end
        end
      end
      ST_WAIT: begin
        // A flush cannot abort the M-op already in EX: the countdown keeps running.
        if (FLUSH || !STALL) begin
          ctrl_d    = NOP_CTRL;
          valid_d   = 1'b0;
          illegal_d = 1'b0;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    READY = RESET && (state_q == ST_RUN) && !STALL;
  end

  assign OUT_VALID        = valid_q;
  assign ILLEGAL          = illegal_q;
  assign MULDIV_START     = start_q;
  assign alu_signal       = ctrl_q.alu;
  assign reg_file_write   = ctrl_q.rfw;
  assign main_mem_write   = ctrl_q.mw;
  assign main_mem_read    = ctrl_q.mr;
  assign branch_control   = ctrl_q.bc;
  assign immediate_select = ctrl_q.imm;
  assign oparand_1_select = ctrl_q.op1;
  assign oparand_2_select = ctrl_q.op2;
  assign reg_write_select = ctrl_q.rws;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode vector table plus
// reset, stall/flush, MUL/DIV sequencing and reset-during-WAIT sequences.
module tb_pipelined_control_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        IN_VALID = 1'b0;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic        READY, OUT_VALID, ILLEGAL, MULDIV_START;
  logic [4:0]  alu_signal;
  logic        reg_file_write;
  logic [2:0]  main_mem_write;
  logic [3:0]  main_mem_read, branch_control, immediate_select;
  logic        oparand_1_select, oparand_2_select;
  logic [1:0]  reg_write_select;

  always #5 CLK = ~CLK;

  pipelined_control_unit #(.MUL_LATENCY(1), .DIV_LATENCY(4), .CNT_W(6)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IN_VALID(IN_VALID),
    .STALL(STALL), .FLUSH(FLUSH), .READY(READY), .OUT_VALID(OUT_VALID),
    .ILLEGAL(ILLEGAL), .MULDIV_START(MULDIV_START), .alu_signal(alu_signal),
    .reg_file_write(reg_file_write), .main_mem_write(main_mem_write),
    .main_mem_read(main_mem_read), .branch_control(branch_control),
    .immediate_select(immediate_select), .oparand_1_select(oparand_1_select),
    .oparand_2_select(oparand_2_select), .reg_write_select(reg_write_select)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic        in_valid;
    logic        flush;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [27:0] NOP_OBS = 28'h0000001;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_DIV   = 32'h0220C1B3;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_LW    = 32'h0000A283;

  // Field order: valid, illegal, start, alu, rfw, mw, mr, bc, imm, op1, op2, rws
  function automatic logic [27:0] ex(input logic v, input logic ill, input logic st,
                                     input logic [4:0] alu, input logic rfw,
                                     input logic [2:0] mw, input logic [3:0] mr,
                                     input logic [3:0] bc, input logic [3:0] imm,
                                     input logic o1, input logic o2, input logic [1:0] rws);
    return {v, ill, st, alu, rfw, mw, mr, bc, imm, o1, o2, rws};
  endfunction

  function automatic logic [27:0] obs();
    return {OUT_VALID, ILLEGAL, MULDIV_START, alu_signal, reg_file_write, main_mem_write,
            main_mem_read, branch_control, immediate_select, oparand_1_select,
            oparand_2_select, reg_write_select};
  endfunction

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ready(input string name, input logic exp);
    tests++;
    if (READY !== exp) begin
      fails++;
      $display("FAIL %s: READY got %b expected %b", name, READY, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic inv, input logic fl,
                         input logic [27:0] exp);
    vec_t v;
    v.instr = instr; v.in_valid = inv; v.flush = fl; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] div_obs;
    div_obs = ex(1, 0, 1, 5'b01100, 1, 3'b000, 4'h0, 4'h0, 4'b0000, 0, 0, 2'b01);

    add_vec(I_ADD,        1, 0, ex(1,0,0,5'b00000,1,3'b000,4'b0000,4'b0000,4'b0000,0,0,2'b01));
    add_vec(32'h0020A223, 1, 0, ex(1,0,0,5'b00000,0,3'b110,4'b0000,4'b0000,4'b0100,0,1,2'b01));
    add_vec(32'h402081B3, 1, 0, ex(1,0,0,5'b10000,1,3'b000,4'b0000,4'b0000,4'b0000,0,0,2'b01));
    add_vec(I_LW,         1, 0, ex(1,0,0,5'b00000,1,3'b000,4'b1010,4'b0000,4'b0010,0,1,2'b00));
    add_vec(32'h0000C283, 1, 0, ex(1,0,0,5'b00000,1,3'b000,4'b1100,4'b0000,4'b1010,0,1,2'b00));
    add_vec(32'h4030D293, 1, 0, ex(1,0,0,5'b10101,1,3'b000,4'b0000,4'b0000,4'b0101,0,1,2'b01));
    add_vec(32'h0010B293, 1, 0, ex(1,0,0,5'b00011,1,3'b000,4'b0000,4'b0000,4'b1010,0,1,2'b01));
    add_vec(32'h123452B7, 1, 0, ex(1,0,0,5'b11000,1,3'b000,4'b0000,4'b0000,4'b0000,0,1,2'b01));
    add_vec(32'h00001297, 1, 0, ex(1,0,0,5'b00000,1,3'b000,4'b0000,4'b0000,4'b0000,1,1,2'b11));
    add_vec(32'h008000EF, 1, 0, ex(1,0,0,5'b00000,1,3'b000,4'b0000,4'b1010,4'b0001,1,1,2'b11));
    add_vec(32'h000280E7, 1, 0, ex(1,0,0,5'b00000,1,3'b000,4'b0000,4'b1010,4'b0010,1,1,2'b11));
    add_vec(32'h0020E463, 1, 0, ex(1,0,0,5'b00000,0,3'b000,4'b0000,4'b1110,4'b0011,1,1,2'b01));
    add_vec(32'h0220B1B3, 1, 0, ex(1,0,1,5'b01011,1,3'b000,4'b0000,4'b0000,4'b1000,0,0,2'b01));
    add_vec(32'h0000007F, 1, 0, ex(1,1,0,5'b00000,0,3'b000,4'b0000,4'b0000,4'b0000,0,0,2'b01));
    add_vec(32'h0020B1B3, 1, 0, ex(1,0,0,5'b00011,1,3'b000,4'b0000,4'b0000,4'b1000,0,0,2'b01));
    add_vec(I_ADD,        0, 0, NOP_OBS);
    add_vec(I_ADD,        1, 1, NOP_OBS);

    // Reset: inputs request a load, but nothing may be accepted while RESET is low.
    RESET = 1'b0; INSTRUCTION = I_ADD; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk_ready($sformatf("reset_ready%0d", i), 1'b0);
      chk($sformatf("reset_nop%0d", i), obs(), NOP_OBS);
    end
    IN_VALID = 1'b0;
    RESET = 1'b1;
    #1 chk_ready("post_reset_ready", 1'b1);
    @(negedge CLK);
    chk("post_reset_nop", obs(), NOP_OBS);

    foreach (vecs[i]) begin
      INSTRUCTION = vecs[i].instr; IN_VALID = vecs[i].in_valid;
      FLUSH = vecs[i].flush; STALL = 1'b0;
      @(negedge CLK);
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    FLUSH = 1'b0;

    // Stall holds a LOAD bundle, then STALL+FLUSH together kills it.
    INSTRUCTION = I_LW; IN_VALID = 1'b1;
    @(negedge CLK);
    chk("stall_load", obs(), vecs[3].exp);
    INSTRUCTION = I_ADD; STALL = 1'b1;
    #1 chk_ready("stall_ready", 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk($sformatf("stall_hold%0d", i), obs(), vecs[3].exp);
    end
    FLUSH = 1'b1;
    @(negedge CLK);
    chk("stall_flush_nop", obs(), NOP_OBS);
    STALL = 1'b0; FLUSH = 1'b0;

    // DIV with latency 4, DIV held on the input so the second one issues back-to-back.
    INSTRUCTION = I_DIV; IN_VALID = 1'b1;
    #1 chk_ready("div_ready_before", 1'b1);
    @(negedge CLK);
    chk("div_issue", obs(), div_obs);
    chk_ready("div_ready_issue", 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk($sformatf("div_wait_nop%0d", i), obs(), NOP_OBS);
      chk_ready($sformatf("div_wait_ready%0d", i), 1'b0);
    end
    @(negedge CLK);
    chk("div_done_nop", obs(), NOP_OBS);
    chk_ready("div_done_ready", 1'b1);
    @(negedge CLK);
    chk("div_b2b_issue", obs(), div_obs);
    IN_VALID = 1'b0;
    STALL = 1'b1;
    @(negedge CLK);
    chk_ready("div_stall_ready", 1'b0);
    STALL = 1'b0; FLUSH = 1'b1;
    @(negedge CLK);
    chk("div_flush_nop", obs(), NOP_OBS);
    FLUSH = 1'b0;
    @(negedge CLK);
    chk_ready("div_stalled_count_ready", 1'b0);
    @(negedge CLK);
    chk_ready("div_stalled_done_ready", 1'b1);

    // MUL with latency 1 never drops READY.
    INSTRUCTION = I_MUL; IN_VALID = 1'b1;
    @(negedge CLK);
    chk("mul_issue", obs(), ex(1,0,1,5'b01000,1,3'b000,4'h0,4'h0,4'b0000,0,0,2'b01));
    chk_ready("mul_ready", 1'b1);
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("mul_after_nop", obs(), NOP_OBS);

    // Reset asserted in the second WAIT cycle of a DIV.
    INSTRUCTION = I_DIV; IN_VALID = 1'b1;
    @(negedge CLK);
    chk("rst_div_issue", obs(), div_obs);
    IN_VALID = 1'b0;
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1 chk("rst_wait_nop", obs(), NOP_OBS);
    chk_ready("rst_wait_ready", 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    #1 chk_ready("rst_release_ready", 1'b1);
    @(negedge CLK);
    INSTRUCTION = I_ADD; IN_VALID = 1'b1;
    @(negedge CLK);
    chk("rst_then_add", obs(), vecs[0].exp);
    IN_VALID = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
